calc_entry_ctrl: RTL and testbench

//  Sequences the 8-digit BCD entry register (blank nibble 4'hF) from decoded keypad events.

---
 rtl/calc_pkg.sv | 48 ++++
 rtl/calc_entry_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, operator/state types and helpers for the calculator entry controller.
package calc_pkg;

  // Keypad event codes as delivered by the decoder.
  localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
  localparam logic [4:0] KEY_ADD       = 5'd10;
  localparam logic [4:0] KEY_DIV       = 5'd13;
  localparam logic [4:0] KEY_EQUALS    = 5'd14;
  localparam logic [4:0] KEY_BKSP      = 5'd15;
  localparam logic [4:0] KEY_CLEAR     = 5'd16;

  // Width of the operand digit counter (holds 0..8).
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_EMPTY  = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_OPWAIT = 3'd2,
    ST_RESULT = 3'd3,
    ST_RELOAD = 3'd4,
    ST_CALC   = 3'd5
  } state_e;

  // States in which the controller can take a new key.
  function automatic logic is_accepting(input state_e s);
    logic v;
    case (s)
      ST_EMPTY, ST_ENTRY, ST_OPWAIT, ST_RESULT: v = 1'b1;
      default:                                  v = 1'b0;
    endcase
    return v;
  endfunction

  // Operator keys 10..13 map onto op codes 0..3.
  function automatic op_e key_to_op(input logic [4:0] code);
    logic [4:0] d;
    d = code - KEY_ADD;
    return op_e'(d[1:0]);
  endfunction

endpackage

// File: rtl/calc_entry_ctrl.sv
// Calculator entry controller: turns accepted keypad events into entry-register
// pulses, tracks the operand digit count and runs the req/ack handshake with the ALU.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic       key_ready,
  output logic [3:0] reg_digit,
  output logic       reg_load,
  output logic       reg_bksp,
  output logic       reg_clear,
  output logic       operand_capture,
  output logic [1:0] op_code,
  output logic       calc_req,
  input  logic       calc_ack,
  output logic [3:0] digit_count,
  output logic       entry_full
);

  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_DIGITS);

  state_e             r_state;
  logic               r_key_ready;
  logic [3:0]         r_digit;
  logic               r_load;
  logic               r_bksp;
  logic               r_clear;
  logic               r_cap;
  op_e                r_op;
  op_e                r_next_op;
  logic               r_chain;
  logic               r_pend;
  logic               r_req;
  logic [COUNT_W-1:0] r_count;
  logic               r_full;
  logic [3:0]         r_hold;

  state_e             w_state_nxt;
  logic               w_ready_nxt;
  logic [3:0]         w_digit_nxt;
  logic               w_load_nxt;
  logic               w_bksp_nxt;
  logic               w_clear_nxt;
  logic               w_cap_nxt;
  op_e                w_op_nxt;
  op_e                w_next_op_nxt;
  logic               w_chain_nxt;
  logic               w_pend_nxt;
  logic               w_req_nxt;
  logic [COUNT_W-1:0] w_count_nxt;
  logic               w_full_nxt;
  logic [3:0]         w_hold_nxt;
  logic               w_accept;

  assign w_accept = key_valid & r_key_ready;

  // Register every output and the FSM/bookkeeping state; reset drops all pulses and req at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_key_ready <= 1'b0;
      r_digit     <= 4'd0;
      r_load      <= 1'b0;
      r_bksp      <= 1'b0;
      r_clear     <= 1'b0;
      r_cap       <= 1'b0;
      r_op        <= OP_ADD;
      r_next_op   <= OP_ADD;
      r_chain     <= 1'b0;
      r_pend      <= 1'b0;
      r_req       <= 1'b0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_hold      <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_key_ready <= w_ready_nxt;
      r_digit     <= w_digit_nxt;
      r_load      <= w_load_nxt;
      r_bksp      <= w_bksp_nxt;
      r_clear     <= w_clear_nxt;
      r_cap       <= w_cap_nxt;
      r_op        <= w_op_nxt;
      r_next_op   <= w_next_op_nxt;
      r_chain     <= w_chain_nxt;
      r_pend      <= w_pend_nxt;
      r_req       <= w_req_nxt;
      r_count     <= w_count_nxt;
      r_full      <= w_full_nxt;
      r_hold      <= w_hold_nxt;
    end
  end

  // Next-state and next-output decode for the current state and any accepted key.
  always_comb begin
    w_state_nxt   = r_state;
    w_digit_nxt   = r_digit;
    w_load_nxt    = 1'b0;
    w_bksp_nxt    = 1'b0;
    w_clear_nxt   = 1'b0;
    w_cap_nxt     = 1'b0;
    w_op_nxt      = r_op;
    w_next_op_nxt = r_next_op;
    w_chain_nxt   = r_chain;
    w_pend_nxt    = r_pend;
    w_req_nxt     = r_req;
    w_count_nxt   = r_count;
    w_full_nxt    = r_full;
    w_hold_nxt    = r_hold;

    case (r_state)
      // Second half of a new-operand digit: the register was blanked last cycle.
      ST_RELOAD: begin
        w_load_nxt  = 1'b1;
        w_digit_nxt = r_hold;
        w_count_nxt = COUNT_W'(1);
        w_state_nxt = ST_ENTRY;
      end

      // Hold req and op stable until the ALU acknowledges.
      ST_CALC: begin
        if (calc_ack) begin
          w_req_nxt   = 1'b0;
          w_count_nxt = '0;
          if (r_chain) begin
            // Chained operator: the result becomes operand A for the new op.
            w_op_nxt    = r_next_op;
            w_cap_nxt   = 1'b1;
            w_state_nxt = ST_OPWAIT;
          end else begin
            w_pend_nxt  = 1'b0;
            w_op_nxt    = OP_ADD;
            w_state_nxt = ST_RESULT;
          end
        end else begin
          w_req_nxt = 1'b1;
        end
      end

      default: begin
        if (w_accept) begin
          if (key_code <= KEY_DIGIT_MAX) begin
            if ((r_state == ST_OPWAIT) || (r_state == ST_RESULT)) begin
              // Start a fresh operand: blank first, load on the following cycle.
              w_clear_nxt = 1'b1;
              w_hold_nxt  = key_code[3:0];
              w_state_nxt = ST_RELOAD;
            end else if (r_count < MAX_CNT) begin
              w_load_nxt  = 1'b1;
              w_digit_nxt = key_code[3:0];
              w_count_nxt = r_count + COUNT_W'(1);
              w_state_nxt = ST_ENTRY;
            end else begin
              w_full_nxt = 1'b1;
            end
          end else if (key_code <= KEY_DIV) begin
            if (((r_state == ST_ENTRY) && !r_pend) || (r_state == ST_RESULT)) begin
              w_cap_nxt   = 1'b1;
              w_op_nxt    = key_to_op(key_code);
              w_pend_nxt  = 1'b1;
              w_count_nxt = '0;
              w_state_nxt = ST_OPWAIT;
            end else if (r_state == ST_ENTRY) begin
              w_req_nxt     = 1'b1;
              w_chain_nxt   = 1'b1;
              w_next_op_nxt = key_to_op(key_code);
              w_state_nxt   = ST_CALC;
            end else if (r_state == ST_OPWAIT) begin
              w_op_nxt = key_to_op(key_code);
            end else begin
              w_op_nxt = r_op;
            end
          end else if (key_code == KEY_EQUALS) begin
            if ((r_state == ST_ENTRY) && r_pend) begin
              w_req_nxt   = 1'b1;
              w_chain_nxt = 1'b0;
              w_state_nxt = ST_CALC;
            end else begin
              w_req_nxt = r_req;
            end
          end else if (key_code == KEY_BKSP) begin
            if (r_state == ST_ENTRY) begin
              w_bksp_nxt  = 1'b1;
              w_full_nxt  = 1'b0;
              w_count_nxt = r_count - COUNT_W'(1);
              if (r_count == COUNT_W'(1)) begin
                w_state_nxt = ST_EMPTY;
              end else begin
                w_state_nxt = ST_ENTRY;
              end
            end else begin
              w_bksp_nxt = 1'b0;
            end
          end else if (key_code == KEY_CLEAR) begin
            w_clear_nxt = 1'b1;
            w_count_nxt = '0;
            w_pend_nxt  = 1'b0;
            w_op_nxt    = OP_ADD;
            w_full_nxt  = 1'b0;
            w_state_nxt = ST_EMPTY;
          end else begin
            // Unused codes are consumed silently.
            w_state_nxt = r_state;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
    endcase

    w_ready_nxt = is_accepting(w_state_nxt);
  end

  assign key_ready       = r_key_ready;
  assign reg_digit       = r_digit;
  assign reg_load        = r_load;
  assign reg_bksp        = r_bksp;
  assign reg_clear       = r_clear;
  assign operand_capture = r_cap;
  assign op_code         = r_op;
  assign calc_req        = r_req;
  assign digit_count     = r_count;
  assign entry_full      = r_full;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: directed scenarios plus random keys,
// compared every cycle against a digit-queue reference model.
module tb_calc_entry_ctrl;

  localparam int MAXD = 8;
  localparam int P_EMPTY = 0, P_ENTRY = 1, P_OPWAIT = 2, P_RESULT = 3, P_RELOAD = 4, P_CALC = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic       key_ready;
  logic [3:0] reg_digit;
  logic       reg_load, reg_bksp, reg_clear, operand_capture;
  logic [1:0] op_code;
  logic       calc_req;
  logic       calc_ack = 1'b0;
  logic [3:0] digit_count;
  logic       entry_full;

  calc_entry_ctrl #(.MAX_DIGITS(MAXD)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .reg_digit(reg_digit), .reg_load(reg_load),
    .reg_bksp(reg_bksp), .reg_clear(reg_clear), .operand_capture(operand_capture),
    .op_code(op_code), .calc_req(calc_req), .calc_ack(calc_ack),
    .digit_count(digit_count), .entry_full(entry_full)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: operand kept as a queue of digits, plus the controller phase.
  int m_dig[$];
  int ph, m_pend, m_chain, m_next, m_hold;
  int e_ready, e_load, e_digit, e_bksp, e_clear, e_cap, e_op, e_req, e_full;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dig.delete();
    ph = P_EMPTY; m_pend = 0; m_chain = 0; m_next = 0; m_hold = 0;
    e_ready = 0; e_load = 0; e_digit = 0; e_bksp = 0; e_clear = 0;
    e_cap = 0; e_op = 0; e_req = 0; e_full = 0;
  endtask

  task automatic model_step(input int kv, input int kc, input int ack);
    int acc;
    acc = kv && e_ready;
    e_load = 0; e_bksp = 0; e_clear = 0; e_cap = 0;
    if (ph == P_RELOAD) begin
      e_load = 1; e_digit = m_hold;
      m_dig.delete(); m_dig.push_back(m_hold);
      ph = P_ENTRY;
    end else if (ph == P_CALC) begin
      if (ack != 0) begin
        e_req = 0; m_dig.delete();
        if (m_chain != 0) begin
          e_op = m_next; e_cap = 1; ph = P_OPWAIT;
        end else begin
          m_pend = 0; e_op = 0; ph = P_RESULT;
        end
      end
    end else if (acc != 0) begin
      if (kc <= 9) begin
        if (ph == P_OPWAIT || ph == P_RESULT) begin
          e_clear = 1; m_hold = kc; ph = P_RELOAD;
        end else if (m_dig.size() < MAXD) begin
          m_dig.push_back(kc); e_load = 1; e_digit = kc; ph = P_ENTRY;
        end else begin
          e_full = 1;
        end
      end else if (kc <= 13) begin
        if ((ph == P_ENTRY && m_pend == 0) || ph == P_RESULT) begin
          e_cap = 1; e_op = kc - 10; m_pend = 1; m_dig.delete(); ph = P_OPWAIT;
        end else if (ph == P_ENTRY) begin
          e_req = 1; m_chain = 1; m_next = kc - 10; ph = P_CALC;
        end else if (ph == P_OPWAIT) begin
          e_op = kc - 10;
        end
      end else if (kc == 14) begin
        if (ph == P_ENTRY && m_pend != 0) begin
          e_req = 1; m_chain = 0; ph = P_CALC;
        end
      end else if (kc == 15) begin
        if (ph == P_ENTRY) begin
          void'(m_dig.pop_back()); e_bksp = 1; e_full = 0;
          if (m_dig.size() == 0) ph = P_EMPTY;
        end
      end else if (kc == 16) begin
        e_clear = 1; m_dig.delete(); m_pend = 0; e_op = 0; e_full = 0; ph = P_EMPTY;
      end
    end
    e_ready = (ph == P_EMPTY || ph == P_ENTRY || ph == P_OPWAIT || ph == P_RESULT) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("key_ready", 32'(key_ready), e_ready);
    check("reg_load", 32'(reg_load), e_load);
    check("reg_bksp", 32'(reg_bksp), e_bksp);
    check("reg_clear", 32'(reg_clear), e_clear);
    check("operand_capture", 32'(operand_capture), e_cap);
    check("calc_req", 32'(calc_req), e_req);
    check("digit_count", 32'(digit_count), m_dig.size());
    check("entry_full", 32'(entry_full), e_full);
    if (e_load != 0) check("reg_digit", 32'(reg_digit), e_digit);
    if (e_req != 0 || ph == P_OPWAIT) check("op_code", 32'(op_code), e_op);
  endtask

  // Called at a negedge: drive inputs, advance the model across the next posedge, compare.
  task automatic drive_cycle(input int kv, input int kc, input int ack);
    key_valid = kv[0];
    key_code  = kc[4:0];
    calc_ack  = ack[0];
    model_step(kv, kc, ack);
    @(negedge clock);
    compare_all();
  endtask

  task automatic key(input int kc);
    drive_cycle(1, kc, 0);
  endtask

  task automatic idle(input int n, input int ack);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, ack);
  endtask

  initial begin
    int r, kv, kc, ack;
    model_reset();
    @(negedge clock);
    check("reset_key_ready", 32'(key_ready), 32'd0);
    check("reset_calc_req", 32'(calc_req), 32'd0);
    check("reset_pulses", 32'({reg_load, reg_bksp, reg_clear, operand_capture}), 32'd0);
    check("reset_count", 32'(digit_count), 32'd0);
    check("reset_full", 32'(entry_full), 32'd0);
    reset = 1'b0;
    idle(1, 0);

    // Digits 1,2,3.
    key(1); key(2); key(3); idle(1, 0);
    check("count_after_123", 32'(digit_count), 32'd3);
    // Overflow then backspace.
    for (int i = 0; i < 6; i++) key(i);
    key(9); idle(1, 0);
    check("entry_full_set", 32'(entry_full), 32'd1);
    key(15); idle(1, 0);
    check("count_after_bksp", 32'(digit_count), 32'd7);
    // 4 + 5 = with late ack.
    key(16); key(4); key(10); key(5); idle(1, 0); key(14);
    idle(2, 0); idle(1, 1); idle(2, 0);
    // 7 * 2 - then +.
    key(16); key(7); key(12); key(2); idle(1, 0); key(11);
    idle(1, 0); idle(1, 1); idle(1, 0); key(10); idle(1, 0);
    // Clear in OPWAIT, then '=' ignored.
    key(16); key(14); idle(2, 0);
    // Stray ack outside CALC.
    key(3); idle(1, 1);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      kc = $urandom_range(0, 9);
      else if (r < 75) kc = $urandom_range(10, 13);
      else if (r < 83) kc = 14;
      else if (r < 90) kc = 15;
      else if (r < 94) kc = 16;
      else             kc = $urandom_range(17, 31);
      kv  = ($urandom_range(0, 9) < 7) ? 1 : 0;
      ack = (ph == P_CALC) ? (($urandom_range(0, 2) == 0) ? 1 : 0)
                           : (($urandom_range(0, 19) == 0) ? 1 : 0);
      drive_cycle(kv, kc, ack);
    end

    // Reset while calc_req is high.
    key(16); key(4); key(10); key(5); idle(1, 0); key(14); idle(1, 0);
    check("req_before_reset", 32'(calc_req), 32'd1);
    reset = 1'b1;
    #1;
    check("req_drops_in_reset", 32'(calc_req), 32'd0);
    check("ready_low_in_reset", 32'(key_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    idle(1, 0);
    check("ready_after_reset", 32'(key_ready), 32'd1);
    key(14); idle(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
